// File: rtl/dct_pkg.sv
// dct_pkg: shared types, constants and helper functions for the 8x8 forward DCT.
//   state_t      : controller states (load, row pass, column pass, output)
//   BLOCK_*      : block geometry
//   *_SHIFT      : fixed-point scaling of the cosine matrix and of the two passes
//   cos_mag()    : |4096 * c(k) * cos(m*pi/16)| for odd-row/even-row angles 1..7
//   sat16()      : clamp a 32-bit signed value to the signed 16-bit range
package dct_pkg;

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_ROW  = 2'd1,
        S_COL  = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    localparam int BLOCK_DIM     = 8;
    localparam int BLOCK_SIZE    = 64;
    localparam int C_SCALE_SHIFT = 12;
    localparam int ROW_SHIFT     = 8;
    localparam int COL_SHIFT     = 16;

    // DC row value: 4096 / sqrt(8), truncated
    localparam logic signed [15:0] C_DC = 16'sd1448;

    // Magnitude of the scaled cosine for angle index m (angle = m*pi/16), m in 1..7
    function automatic logic signed [15:0] cos_mag(input logic [4:0] m);
        logic signed [15:0] mag;
        case (m)
            5'd1:    mag = 16'sd2008;
            5'd2:    mag = 16'sd1892;
            5'd3:    mag = 16'sd1702;
            5'd4:    mag = 16'sd1448;
            5'd5:    mag = 16'sd1137;
            5'd6:    mag = 16'sd783;
            5'd7:    mag = 16'sd399;
            default: mag = 16'sd0;
        endcase
        return mag;
    endfunction

    // Saturate to [-32768, 32767]
    function automatic logic signed [15:0] sat16(input logic signed [31:0] v);
        logic signed [15:0] r;
        if (v > 32'sd32767) begin
            r = 16'sh7fff;
        end else if (v < -32'sd32768) begin
            r = 16'sh8000;
        end else begin
            r = v[15:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/dct_coeff_rom.sv
// dct_coeff_rom: combinational lookup of the 4096-scaled DCT-II cosine matrix.
//   row   : matrix row k (frequency index)
//   col   : matrix column j (sample index)
//   coeff : C[k][j], signed 16-bit
module dct_coeff_rom
    import dct_pkg::*;
(
    input  logic [2:0]         row,
    input  logic [2:0]         col,
    output logic signed [15:0] coeff
);

    logic [4:0] angle_s;
    logic [4:0] fold_s;

    // The angle (2j+1)*k is taken mod 32 (cosine period), folded onto 0..16 by
    // symmetry, and the sign comes from which side of pi/2 the folded angle lies.
    always_comb begin
        angle_s = 5'({col, 1'b1}) * 5'(row);
        if (angle_s > 5'd16) begin
            fold_s = 5'd0 - angle_s;
        end else begin
            fold_s = angle_s;
        end
        if (row == 3'd0) begin
            coeff = C_DC;
        end else if (fold_s <= 5'd8) begin
            coeff = cos_mag(fold_s);
        end else begin
            coeff = -cos_mag(5'd16 - fold_s);
        end
    end

endmodule

// File: rtl/fdct_8x8.sv
// fdct_8x8: serial 8x8 forward 2-D DCT, S = C * P * C^T, one MAC per cycle.
//   clk, rst             : rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready    : pixel handshake, in_data = unsigned 8-bit pixel (row-major)
//   out_valid/out_ready  : coefficient handshake, out_data = signed 16-bit S[u][v] (row-major)
//   out_last             : marks the 64th coefficient of the block
//   busy                 : high from the first accepted pixel until the final output handshake
module fdct_8x8
    import dct_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        out_last,
    output logic        busy
);

    localparam logic [8:0] CNT_LAST_PIX = 9'(BLOCK_SIZE - 1);
    localparam logic [8:0] CNT_LAST_MAC = 9'(BLOCK_SIZE * BLOCK_DIM - 1);

    state_t             state_r;
    state_t             state_s;
    logic [8:0]         cnt_r;
    logic signed [31:0] acc_r;
    logic               in_ready_r;
    logic               out_valid_r;
    logic               out_last_r;
    logic               busy_r;
    logic [15:0]        out_data_r;

    logic [7:0]         pix_mem [BLOCK_SIZE];
    logic signed [15:0] t_mem   [BLOCK_SIZE];
    logic signed [15:0] res_mem [BLOCK_SIZE];

    logic [5:0]         elem_s;
    logic [2:0]         tap_s;
    logic [2:0]         rom_row_s;
    logic signed [15:0] coeff_s;
    logic signed [15:0] t_sel_s;
    logic signed [31:0] coeff_ext_s;
    logic signed [31:0] operand_s;
    logic signed [31:0] prod_s;
    logic signed [31:0] sum_s;
    logic [5:0]         next_idx_s;
    logic               in_fire_s;
    logic               out_fire_s;

    // During the passes cnt_r = {element index, tap index}
    assign elem_s     = cnt_r[8:3];
    assign tap_s      = cnt_r[2:0];
    assign next_idx_s = cnt_r[5:0] + 6'd1;
    assign in_fire_s  = in_valid & in_ready_r;
    assign out_fire_s = out_valid_r & out_ready;

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_last  = out_last_r;
    assign busy      = busy_r;

    // Row pass: element (r,k), tap j uses C[k][j]; column pass: element (u,c), tap r uses C[u][r]
    dct_coeff_rom u_rom (
        .row   (rom_row_s),
        .col   (tap_s),
        .coeff (coeff_s)
    );

    // MAC operand selection and accumulate; tap 0 restarts the sum
    always_comb begin
        t_sel_s     = t_mem[{tap_s, elem_s[2:0]}];
        coeff_ext_s = {{16{coeff_s[15]}}, coeff_s};
        if (state_r == S_COL) begin
            rom_row_s = elem_s[5:3];
            operand_s = {{16{t_sel_s[15]}}, t_sel_s};
        end else begin
            rom_row_s = elem_s[2:0];
            operand_s = {24'd0, pix_mem[{elem_s[5:3], tap_s}]};
        end
        prod_s = operand_s * coeff_ext_s;
        if (tap_s == 3'd0) begin
            sum_s = prod_s;
        end else begin
            sum_s = acc_r + prod_s;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_LOAD;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_LOAD: begin
                if (in_fire_s && cnt_r == CNT_LAST_PIX) begin
                    state_s = S_ROW;
                end else begin
                    state_s = S_LOAD;
                end
            end
            S_ROW: begin
                if (cnt_r == CNT_LAST_MAC) begin
                    state_s = S_COL;
                end else begin
                    state_s = S_ROW;
                end
            end
            S_COL: begin
                if (cnt_r == CNT_LAST_MAC) begin
                    state_s = S_OUT;
                end else begin
                    state_s = S_COL;
                end
            end
            S_OUT: begin
                if (out_fire_s && out_last_r) begin
                    state_s = S_LOAD;
                end else begin
                    state_s = S_OUT;
                end
            end
            default: state_s = S_LOAD;
        endcase
    end

    // Counter, accumulator and registered handshake outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r       <= 9'd0;
            acc_r       <= 32'sd0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            out_data_r  <= 16'd0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                S_LOAD: begin
                    if (in_fire_s) begin
                        busy_r <= 1'b1;
                        if (cnt_r == CNT_LAST_PIX) begin
                            cnt_r      <= 9'd0;
                            in_ready_r <= 1'b0;
                        end else begin
                            cnt_r <= cnt_r + 9'd1;
                        end
                    end
                end
                S_ROW: begin
                    acc_r <= sum_s;
                    cnt_r <= cnt_r + 9'd1;
                end
                S_COL: begin
                    acc_r <= sum_s;
                    cnt_r <= cnt_r + 9'd1;
                    if (cnt_r == CNT_LAST_MAC) begin
                        // S[0][0] was finished long ago, so it can be presented immediately
                        out_valid_r <= 1'b1;
                        out_last_r  <= 1'b0;
                        out_data_r  <= res_mem[6'd0];
                    end
                end
                S_OUT: begin
                    if (out_fire_s) begin
                        if (out_last_r) begin
                            cnt_r       <= 9'd0;
                            out_valid_r <= 1'b0;
                            out_last_r  <= 1'b0;
                            in_ready_r  <= 1'b1;
                            busy_r      <= 1'b0;
                        end else begin
                            cnt_r      <= cnt_r + 9'd1;
                            out_data_r <= res_mem[next_idx_s];
                            out_last_r <= (cnt_r[5:0] == 6'd62);
                        end
                    end
                end
                default: begin
                    cnt_r <= 9'd0;
                end
            endcase
        end
    end

    // Pixel, intermediate and result storage; overwritten before every read, so unreset
    always_ff @(posedge clk) begin
        if (state_r == S_LOAD && in_fire_s) begin
            pix_mem[cnt_r[5:0]] <= in_data;
        end
        if (state_r == S_ROW && tap_s == 3'd7) begin
            t_mem[elem_s] <= 16'(sum_s >>> ROW_SHIFT);
        end
        if (state_r == S_COL && tap_s == 3'd7) begin
            res_mem[elem_s] <= sat16(sum_s >>> COL_SHIFT);
        end
    end

endmodule

// File: tb/tb_fdct_8x8.sv
// tb_fdct_8x8: self-checking bench for fdct_8x8. A matrix-level reference model
// (explicit cosine table, plain integer sums with floor shifts) produces the
// expected coefficient stream; directed and random blocks are pushed through
// the DUT under several out_ready patterns.
module tb_fdct_8x8;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_last;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  pix_q [$];
    logic [15:0] exp_q [$];
    bit          exp_l [$];

    int cmat [8][8] = '{
        '{1448,  1448,  1448,  1448,  1448,  1448,  1448,  1448},
        '{2008,  1702,  1137,   399,  -399, -1137, -1702, -2008},
        '{1892,   783,  -783, -1892, -1892,  -783,   783,  1892},
        '{1702,  -399, -2008, -1137,  1137,  2008,   399, -1702},
        '{1448, -1448, -1448,  1448,  1448, -1448, -1448,  1448},
        '{1137, -2008,   399,  1702, -1702,  -399,  2008, -1137},
        '{ 783, -1892,  1892,  -783,  -783,  1892, -1892,   783},
        '{ 399, -1137,  1702, -2008,  2008, -1702,  1137,  -399}
    };

    fdct_8x8 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Queue one block of pixels and its expected coefficients.
    // kind 0: every pixel = val; 1: P[0][0] = val, others 0; 2: random pixels
    task automatic load_block(input int kind, input int val);
        int      blk [64];
        int      t   [64];
        int      acc;
        int      v;
        shortint tv;
        for (int i = 0; i < 64; i++) begin
            case (kind)
                0:       blk[i] = val;
                1:       blk[i] = (i == 0) ? val : 0;
                default: blk[i] = int'($urandom_range(0, 255));
            endcase
            pix_q.push_back(8'(blk[i]));
        end
        // T = (P * C^T) >>> 8, kept as 16-bit signed
        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < 8; k++) begin
                acc = 0;
                for (int j = 0; j < 8; j++) acc += blk[r*8 + j] * cmat[k][j];
                tv = shortint'(acc >>> 8);
                t[r*8 + k] = tv;
            end
        end
        // S = (C * T) >>> 16, saturated, emitted row-major
        for (int u = 0; u < 8; u++) begin
            for (int c = 0; c < 8; c++) begin
                acc = 0;
                for (int r = 0; r < 8; r++) acc += cmat[u][r] * t[r*8 + c];
                v = acc >>> 16;
                if (v > 32767) v = 32767;
                if (v < -32768) v = -32768;
                exp_q.push_back(16'(v));
                exp_l.push_back(u == 7 && c == 7);
            end
        end
    endtask

    // Drive queued pixels and consume expected outputs.
    // mode 0: out_ready=1; 1: out_ready toggles 1/0; 2: random out_ready
    task automatic run(input int mode);
        int          cyc = 0;
        int          last_in = -100000;
        int          n_in = 0;
        int          n_lastout = 0;
        bit          prev_stall = 1'b0;
        bit          prev_valid;
        logic [15:0] prev_data = 16'd0;
        bit          prev_last = 1'b0;
        bit          fin;
        bit          fout;
        bit          flast;
        prev_valid = out_valid;
        while ((pix_q.size() > 0 || exp_q.size() > 0) && cyc < 8000) begin
            in_valid = (pix_q.size() > 0);
            in_data  = (pix_q.size() > 0) ? pix_q[0] : 8'd0;
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 2 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (prev_stall) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_data", 32'(out_data), 32'(prev_data));
                check("stall_last", 32'(out_last), 32'(prev_last));
            end
            if (!prev_valid && out_valid) begin
                check("latency", 32'(cyc - last_in), 32'd1025);
            end
            if (n_in >= 64 * (n_lastout + 1)) begin
                check("in_ready_low", 32'(in_ready), 32'd0);
                check("busy_high", 32'(busy), 32'd1);
            end
            fin   = in_valid && in_ready;
            fout  = out_valid && out_ready;
            flast = out_last;
            if (fout) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 32'(out_valid), 32'd0);
                end else begin
                    check("coef", 32'(out_data), 32'(exp_q[0]));
                    check("last", 32'(out_last), 32'(exp_l[0]));
                    void'(exp_q.pop_front());
                    void'(exp_l.pop_front());
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
            prev_valid = out_valid;
            @(posedge clk);
            #1;
            if (fin) begin
                void'(pix_q.pop_front());
                n_in++;
                if (n_in % 64 == 0) last_in = cyc;
            end
            if (fout && flast) begin
                n_lastout++;
                if (pix_q.size() > 0) check("in_ready_after_last", 32'(in_ready), 32'd1);
            end
            cyc++;
        end
        check("run_complete", 32'(pix_q.size() + exp_q.size()), 32'd0);
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'd0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // All zeros
        load_block(0, 0);
        run(0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_in_ready", 32'(in_ready), 32'd1);

        // All 255 (S[0][0] = 2039), latency checked inside run
        load_block(0, 255);
        run(0);

        // All 128 with out_ready toggling (S[0][0] = 1023)
        load_block(0, 128);
        run(1);

        // Single impulse at P[0][0] (S[0][0] = 31)
        load_block(1, 255);
        run(0);

        // Reset in the middle of the row pass, then a clean all-255 block
        load_block(0, 255);
        exp_q.delete();
        exp_l.delete();
        run(0);
        repeat (100) @(posedge clk);
        #1;
        check("mid_row_busy", 32'(busy), 32'd1);
        check("mid_row_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b1;
        #1;
        check("async_rst_in_ready", 32'(in_ready), 32'd1);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        load_block(0, 255);
        run(0);

        // Two blocks back-to-back with in_valid held high
        load_block(2, 0);
        load_block(0, 255);
        run(0);

        // Two random blocks back-to-back, random output back-pressure
        load_block(2, 0);
        load_block(2, 0);
        run(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fdct_8x8.md
FDCT_8X8 -- requirements
Module: fdct_8x8

Interface
REQ-001 The block SHALL have one clock and one reset: the reset is asynchronous and active-high.
REQ-002 Clock  input  1  rising-edge clock for all state.
REQ-003 Reset  input  1  asynchronous active-high reset.
REQ-004 in_valid  input  1  pixel sample valid.
REQ-005 in_ready  output  1  block accepts a sample this cycle.
REQ-006 in_data  input  8  unsigned pixel, row-major order within the 8x8 block.
REQ-007 out_valid  output  1  coefficient valid.
REQ-008 out_ready  input  1  downstream accepts the coefficient.
REQ-009 out_data  output  16  signed DCT coefficient S[u][v], row-major order.
REQ-010 out_last  output  1  high with the 64th coefficient of the block.
REQ-011 busy  output  1  high from the first accepted sample until the last output handshake.

Function
REQ-012 The block SHALL compute the forward 2-D DCT S = C·P·Cᵀ. C is the 8x8 cosine matrix scaled by 4096:
- C[0][*] = 1448.
- Row 1 = 2008, 1702, 1137, 399, then the same values negated in reverse order.
- Rows 2–7 follow the standard DCT-II sign pattern, with magnitudes taken from {1892, 783} for even rows and {2008, 1702, 1137, 399} for odd rows (row 4 is ±1448).
REQ-013 The FSM states SHALL be S_LOAD, S_ROW, S_COL, S_OUT, with these transitions:
- S_LOAD→S_ROW after the 64th input handshake.
- S_ROW→S_COL after 512 cycles.
- S_COL→S_OUT after 512 cycles.
- S_OUT→S_LOAD after the out_last handshake.
REQ-014 in_ready SHALL be 1 only in S_LOAD; a sample is accepted when in_valid and in_ready are both 1; in_valid outside S_LOAD SHALL be ignored.
REQ-015 S_ROW SHALL compute T[r][k] = (Σj P[r][j]·C[k][j]) >>> 8 with one multiply-accumulate per cycle, 8 cycles per element, 64 elements; T is stored as 16-bit signed.
REQ-016 S_COL SHALL compute S[u][c] = (Σr C[u][r]·T[r][c]) >>> 16 with one multiply-accumulate per cycle, 8 cycles per element.
- Results are saturated to [-32768, 32767] and stored in a 64-entry result buffer.
REQ-017 Accumulators SHALL be at least 32-bit signed; shifts are arithmetic (floor).
REQ-018 Latency: if the last input handshake occurs in cycle 0, then:
- The block is in S_ROW in cycles 1–512.
- The block is in S_COL in cycles 513–1024.
- out_valid SHALL be 1 in cycle 1025.
REQ-019 In S_OUT, out_valid SHALL stay 1 until all 64 coefficients are handshaken.
- out_data and out_last SHALL hold stable while out_valid=1 and out_ready=0.
REQ-020 out_last SHALL be 1 only for index 63.
REQ-021 The block SHALL accept the next block's first sample in the cycle after the out_last handshake.
- No overlap between blocks is permitted.
REQ-022 busy SHALL be 0 in S_LOAD with a sample count of 0, and 1 otherwise.

Reset
REQ-023 Reset SHALL asynchronously force the following, discarding any partial block:
- State = S_LOAD; all counters = 0.
- in_ready=1 (from the first cycle after deassertion).
- out_valid=0, out_last=0, out_data=0, busy=0.
REQ-024 The T and result buffers need no reset; their contents are never observable before being rewritten.

Structure
REQ-025 A shared package dct_pkg SHALL hold:
- The state enum.
- BLOCK_DIM=8, BLOCK_SIZE=64, C_SCALE_SHIFT=12, ROW_SHIFT=8, COL_SHIFT=16.
REQ-026 Coefficient lookup SHALL be one combinational sub-module, dct_coeff_rom, with inputs row[2:0] and col[2:0] and a 16-bit signed output; it is instantiated once.

Verification
REQ-027 All 64 pixels = 0 → 64 coefficients all 0; out_last on the 64th.
REQ-028 All 64 pixels = 255 → S[0][0]=2039, all others 0; first out_valid exactly 1025 cycles after the last input handshake.
REQ-029 All pixels = 128, out_ready toggled 1/0 every cycle → S[0][0]=1023, others 0; out_data held stable during stalls; 64 handshakes total.
REQ-030 P[0][0]=255, others 0 → S[0][0]=31.
REQ-031 Reset asserted mid-S_ROW, then the all-255 block sent → state = S_LOAD; output identical to REQ-028.
REQ-032 Two blocks back-to-back, with in_valid held 1 throughout → in_ready=0 from the 64th handshake through S_OUT; the second block is accepted starting the cycle after the first block's out_last handshake; both outputs correct.
